// File: rtl/mix_column_stage.sv
// AES MixColumns over the statemt RAM: reads each column through both ports,
// mixes it in GF(2^8) and writes it back in place under the ap_start/ap_done handshake.
module mix_column_stage #(
    parameter int NUM_COLS = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [ADDR_W-1:0] statemt_address0,
    output logic              statemt_ce0,
    output logic              statemt_we0,
    output logic [DATA_W-1:0] statemt_d0,
    input  logic [DATA_W-1:0] statemt_q0,
    output logic [ADDR_W-1:0] statemt_address1,
    output logic              statemt_ce1,
    output logic              statemt_we1,
    output logic [DATA_W-1:0] statemt_d1,
    input  logic [DATA_W-1:0] statemt_q1
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD01 = 3'd1,
        S_RD23 = 3'd2,
        S_CAP  = 3'd3,
        S_WR01 = 3'd4,
        S_WR23 = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [1:0] LAST_J = 2'(NUM_COLS - 1);

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_j;
    logic [7:0]  r_s0, r_s1, r_s2, r_s3;
    logic [7:0]  w_r0, w_r1, w_r2, w_r3;
    logic        w_unused_q;

    // Only the low byte of each word carries state.
    assign w_unused_q = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8]};

    assign w_r0 = xt(r_s0) ^ xt(r_s1) ^ r_s1 ^ r_s2 ^ r_s3;
    assign w_r1 = r_s0 ^ xt(r_s1) ^ xt(r_s2) ^ r_s2 ^ r_s3;
    assign w_r2 = r_s0 ^ r_s1 ^ xt(r_s2) ^ xt(r_s3) ^ r_s3;
    assign w_r3 = xt(r_s0) ^ r_s0 ^ r_s1 ^ r_s2 ^ xt(r_s3);

    // State register, column counter and captured column bytes.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
            r_j     <= 2'd0;
            r_s0    <= 8'h00;
            r_s1    <= 8'h00;
            r_s2    <= 8'h00;
            r_s3    <= 8'h00;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (ap_start) r_j <= 2'd0;
                    else          r_j <= r_j;
                end
                S_RD23: begin
                    r_s0 <= statemt_q0[7:0];
                    r_s1 <= statemt_q1[7:0];
                end
                S_CAP: begin
                    r_s2 <= statemt_q0[7:0];
                    r_s3 <= statemt_q1[7:0];
                end
                S_WR23: r_j <= r_j + 2'd1;
                default: r_j <= r_j;
            endcase
        end
    end

    // Next-state and RAM/handshake decode; outputs depend only on state so reset drops them at once.
    always_comb begin
        w_next_state     = r_state;
        ap_done          = 1'b0;
        ap_idle          = 1'b0;
        statemt_ce0      = 1'b0;
        statemt_we0      = 1'b0;
        statemt_ce1      = 1'b0;
        statemt_we1      = 1'b0;
        statemt_address0 = {ADDR_W{1'b0}};
        statemt_address1 = {ADDR_W{1'b0}};
        statemt_d0       = {DATA_W{1'b0}};
        statemt_d1       = {DATA_W{1'b0}};
        case (r_state)
            S_IDLE: begin
                ap_idle = !ap_start;
                if (ap_start) w_next_state = S_RD01;
                else          w_next_state = S_IDLE;
            end
            S_RD01: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_address0 = ADDR_W'({r_j, 2'd0});
                statemt_address1 = ADDR_W'({r_j, 2'd1});
                w_next_state     = S_RD23;
            end
            S_RD23: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_address0 = ADDR_W'({r_j, 2'd2});
                statemt_address1 = ADDR_W'({r_j, 2'd3});
                w_next_state     = S_CAP;
            end
            S_CAP: w_next_state = S_WR01;
            S_WR01: begin
                statemt_ce0      = 1'b1;
                statemt_we0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_we1      = 1'b1;
                statemt_address0 = ADDR_W'({r_j, 2'd0});
                statemt_address1 = ADDR_W'({r_j, 2'd1});
                statemt_d0       = DATA_W'(w_r0);
                statemt_d1       = DATA_W'(w_r1);
                w_next_state     = S_WR23;
            end
            S_WR23: begin
                statemt_ce0      = 1'b1;
                statemt_we0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_we1      = 1'b1;
                statemt_address0 = ADDR_W'({r_j, 2'd2});
                statemt_address1 = ADDR_W'({r_j, 2'd3});
                statemt_d0       = DATA_W'(w_r2);
                statemt_d1       = DATA_W'(w_r3);
                if (r_j == LAST_J) w_next_state = S_DONE;
                else               w_next_state = S_RD01;
            end
            S_DONE: begin
                ap_done      = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign ap_ready = ap_done;

endmodule

// File: tb/tb_mix_column_stage.sv
// Directed bench for mix_column_stage: behavioural dual-port statemt RAM,
// hand-computed MixColumns vectors, latency, held-start and mid-write reset checks.
module tb_mix_column_stage;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  a0, a1;
    logic        ce0, we0, ce1, we1;
    logic [31:0] d0, d1, q0, q1;

    logic [31:0] mem    [0:31];
    logic [31:0] shadow [0:31];
    logic        tb_we = 1'b0;
    logic        tb_restore = 1'b0;
    logic [4:0]  tb_addr = 5'd0;
    logic [31:0] tb_wdata = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ap_clk = ~ap_clk;

    mix_column_stage dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .statemt_address0(a0), .statemt_ce0(ce0), .statemt_we0(we0),
        .statemt_d0(d0), .statemt_q0(q0),
        .statemt_address1(a1), .statemt_ce1(ce1), .statemt_we1(we1),
        .statemt_d1(d1), .statemt_q1(q1)
    );

    // Synchronous-read RAM plus a bench load port and one-edge restore from the shadow copy.
    always @(posedge ap_clk) begin
        if (tb_we) begin
            mem[tb_addr]    <= tb_wdata;
            shadow[tb_addr] <= tb_wdata;
        end
        if (tb_restore) begin
            for (int i = 0; i < 32; i++) mem[i] <= shadow[i];
        end
        if (ce0) begin
            if (we0) mem[a0] <= d0;
            else     q0 <= mem[a0];
        end
        if (ce1) begin
            if (we1) mem[a1] <= d1;
            else     q1 <= mem[a1];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_write(input int addr, input logic [31:0] data);
        @(negedge ap_clk);
        tb_we    = 1'b1;
        tb_addr  = 5'(addr);
        tb_wdata = data;
        @(negedge ap_clk);
        tb_we    = 1'b0;
    endtask

    task automatic load_col(input int c, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        mem_write(c*4+0, w0);
        mem_write(c*4+1, w1);
        mem_write(c*4+2, w2);
        mem_write(c*4+3, w3);
    endtask

    task automatic check_col(input string tag, input int c, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        check_eq({tag, "_w0"}, mem[c*4+0], {24'd0, e0});
        check_eq({tag, "_w1"}, mem[c*4+1], {24'd0, e1});
        check_eq({tag, "_w2"}, mem[c*4+2], {24'd0, e2});
        check_eq({tag, "_w3"}, mem[c*4+3], {24'd0, e3});
    endtask

    // Caller raises ap_start at a negedge; counts edges until ap_done is seen.
    task automatic wait_done(input string tag, input int exp_cyc, input bit hold);
        int cyc = 0;
        bit seen = 1'b0;
        bit idle_hi = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge ap_clk);
            cyc++;
            @(negedge ap_clk);
            if (!hold) ap_start = 1'b0;
            if (ap_idle) idle_hi = 1'b1;
            if (ap_done) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_ready"}, 32'(ap_ready), 32'd1);
        if (hold) check_eq({tag, "_idle_low"}, 32'(idle_hi), 32'd0);
    endtask

    initial begin
        int done_cnt;
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        check_eq("rst_done", 32'(ap_done), 32'd0);
        check_eq("rst_ready", 32'(ap_ready), 32'd0);
        check_eq("rst_ce", 32'({ce0, ce1}), 32'd0);
        check_eq("rst_we", 32'({we0, we1}), 32'd0);
        check_eq("rst_idle", 32'(ap_idle), 32'd1);
        ap_start = 1'b1;
        #1;
        check_eq("rst_idle_start", 32'(ap_idle), 32'd0);
        ap_start = 1'b0;

        // Basic run: four reference columns
        load_col(0, 32'hdb, 32'h13, 32'h53, 32'h45);
        load_col(1, 32'hf2, 32'h0a, 32'h22, 32'h5c);
        load_col(2, 32'h01, 32'h01, 32'h01, 32'h01);
        load_col(3, 32'hc6, 32'hc6, 32'hc6, 32'hc6);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b1;
        wait_done("run1", 21, 1'b0);
        @(negedge ap_clk);
        check_eq("run1_done_pulse", 32'(ap_done), 32'd0);
        check_eq("run1_idle_after", 32'(ap_idle), 32'd1);
        check_col("run1_c0", 0, 8'h8e, 8'h4d, 8'ha1, 8'hbc);
        check_col("run1_c1", 1, 8'h9f, 8'hdc, 8'h58, 8'h9d);
        check_col("run1_c2", 2, 8'h01, 8'h01, 8'h01, 8'h01);
        check_col("run1_c3", 3, 8'hc6, 8'hc6, 8'hc6, 8'hc6);

        // Upper-bit garbage, held start, two back-to-back runs
        load_col(0, 32'hFFFF_FFDB, 32'hA5A5_A513, 32'h0000_0153, 32'h1234_5645);
        load_col(1, 32'hd4, 32'hd4, 32'hd4, 32'hd5);
        load_col(2, 32'hdead_be01, 32'h01, 32'h01, 32'hffff_ff01);
        load_col(3, 32'hf2, 32'h0a, 32'h22, 32'h5c);
        @(negedge ap_clk);
        ap_start = 1'b1;
        wait_done("held1", 21, 1'b1);
        check_col("held1_c0", 0, 8'h8e, 8'h4d, 8'ha1, 8'hbc);
        check_col("held1_c1", 1, 8'hd5, 8'hd5, 8'hd7, 8'hd6);
        check_col("held1_c2", 2, 8'h01, 8'h01, 8'h01, 8'h01);
        check_col("held1_c3", 3, 8'h9f, 8'hdc, 8'h58, 8'h9d);
        tb_restore = 1'b1;
        @(negedge ap_clk);
        tb_restore = 1'b0;
        check_eq("held_restart_idle", 32'(ap_idle), 32'd0);
        check_eq("held_restart_done", 32'(ap_done), 32'd0);
        wait_done("held2", 21, 1'b1);
        check_col("held2_c0", 0, 8'h8e, 8'h4d, 8'ha1, 8'hbc);
        check_col("held2_c1", 1, 8'hd5, 8'hd5, 8'hd7, 8'hd6);
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);

        // Reset during WR01 of column 2
        load_col(0, 32'hdb, 32'h13, 32'h53, 32'h45);
        load_col(1, 32'h01, 32'h01, 32'h01, 32'h01);
        load_col(2, 32'hd4, 32'hd4, 32'hd4, 32'hd5);
        load_col(3, 32'hf2, 32'h0a, 32'h22, 32'h5c);
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
        end
        check_eq("abort_in_wr01_we", 32'(we0), 32'd1);
        check_eq("abort_in_wr01_addr", 32'(a0), 32'd8);
        ap_rst_n = 1'b0;
        #1;
        check_eq("abort_ce", 32'({ce0, ce1}), 32'd0);
        check_eq("abort_we", 32'({we0, we1}), 32'd0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge ap_clk);
            if (ap_done) done_cnt++;
        end
        ap_rst_n = 1'b1;
        repeat (30) begin
            @(negedge ap_clk);
            if (ap_done) done_cnt++;
        end
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        check_col("abort_c0", 0, 8'h8e, 8'h4d, 8'ha1, 8'hbc);
        check_col("abort_c1", 1, 8'h01, 8'h01, 8'h01, 8'h01);
        check_col("abort_c2", 2, 8'hd4, 8'hd4, 8'hd4, 8'hd5);
        check_col("abort_c3", 3, 8'hf2, 8'h0a, 8'h22, 8'h5c);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
